// File: rtl/l2_xbar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l2_xbar_pkg
//  Description : Shared types and constants for the L2 crossbar response path.
//                resp_entry_t is the in-flight response descriptor at the
//                default initiator count; outstanding_width() sizes the
//                in-flight counter of a response demux.
//  Revision    : 1.0  initial release
// ============================================================================
package l2_xbar_pkg;

    localparam int c_l2_id_width    = 16;
    localparam int c_l2_mem_latency = 1;
    localparam int c_l2_out_reg     = 0;

    // One in-flight response slot: valid occupancy, opcode, one-hot initiator.
    typedef struct packed {
        logic                     valid;
        logic                     wen;
        logic [c_l2_id_width-1:0] id;
    } resp_entry_t;

    // Counter must hold 0..(mem_latency + out_reg) inclusive.
    function automatic int outstanding_width(input int mem_latency, input int out_reg);
        int w;
        w = $clog2(mem_latency + out_reg + 1);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int c_l2_outstanding_w = outstanding_width(c_l2_mem_latency, c_l2_out_reg);

endpackage : l2_xbar_pkg
`default_nettype wire

// File: rtl/resp_demux_l2_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : resp_delay_line_l2
//  Description : Generic N-stage valid + payload shift register, no stall.
//                An entry written at cycle t appears on out_* at t+N.
//  Ports       : clk, rst_n (async, active low)
//                in_valid / in_data   : entry captured every cycle
//                out_valid / out_data : entry leaving the last stage
//  Revision    : 1.0  initial release
// ============================================================================
module resp_delay_line_l2 #(
    parameter int N = 1,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    // Valid bit carried as the MSB of each stage word.
    logic [W:0] r_pipe [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= {in_valid, in_data};
            for (int i = 1; i < N; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign out_valid = r_pipe[N-1][W];
    assign out_data  = r_pipe[N-1][W-1:0];

endmodule : resp_delay_line_l2
`default_nettype wire

// File: rtl/resp_demux_l2.sv
`default_nettype none
// ============================================================================
//  Module      : resp_demux_l2
//  Description : Response demux at one L2 bank port. Records each granted
//                request (ID, opcode), delays it by the bank latency and
//                steers the bank read data back as a one-hot r_valid.
//                Fully pipelined, never back-pressured.
//  Ports       : clk, rst_n            clock, async active-low reset
//                data_req_i/gnt_i      request handshake at the bank
//                data_wen_i            1 = read, 0 = write
//                data_ID_i             one-hot initiator ID
//                data_r_rdata_i/rtag_i bank read data/tag
//                data_r_valid_o        one-hot response valid
//                data_r_rdata_o/rtag_o response data/tag (broadcast)
//                outstanding_o         in-flight transaction count
//                err_id_o              pulse: handshake with non-one-hot ID
//  Revision    : 1.0  initial release
// ============================================================================
module resp_demux_l2
    import l2_xbar_pkg::*;
#(
    parameter int ID_WIDTH      = 16,
    parameter int DATA_WIDTH    = 64,
    parameter int TAG_WIDTH     = 8,
    parameter int MEM_LATENCY   = 1,
    parameter int OUT_REG       = 0,
    parameter int RESP_ON_WRITE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_req_i,
    input  logic                  data_gnt_i,
    input  logic                  data_wen_i,
    input  logic [ID_WIDTH-1:0]   data_ID_i,
    input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
    input  logic [TAG_WIDTH-1:0]  data_r_rtag_i,
    output logic [ID_WIDTH-1:0]   data_r_valid_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic [TAG_WIDTH-1:0]  data_r_rtag_o,
    output logic [outstanding_width(MEM_LATENCY, OUT_REG)-1:0] outstanding_o,
    output logic                  err_id_o
);

    localparam int c_cnt_w = outstanding_width(MEM_LATENCY, OUT_REG);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic c_resp_on_write = (RESP_ON_WRITE != 0);

    // Same shape as resp_entry_t, sized by this instance's ID width; valid
    // travels separately through the delay line.
    typedef struct packed {
        logic                wen;
        logic [ID_WIDTH-1:0] id;
    } payload_t;

    logic                w_hs;
    logic                w_id_ok;
    logic                w_cap_valid;
    payload_t            w_cap_payload;
    logic                w_last_valid;
    payload_t            w_last_payload;
    logic                w_resp;
    logic [ID_WIDTH-1:0] w_rvalid_nxt;
    logic                w_leave;
    logic                r_err;
    logic [c_cnt_w-1:0]  r_outstanding;

    // ------------------------------------------------------------------
    // Handshake capture and ID check. A bad ID is flagged and the slot is
    // filled with an invalid entry so nothing ever responds to it.
    // ------------------------------------------------------------------
    assign w_hs        = data_req_i & data_gnt_i;
    assign w_id_ok     = (data_ID_i != '0) &&
                         ((data_ID_i & (data_ID_i - ID_WIDTH'(1))) == '0);
    assign w_cap_valid = w_hs & w_id_ok;

    assign w_cap_payload.wen = data_wen_i;
    assign w_cap_payload.id  = data_ID_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_hs & ~w_id_ok;
        end
    end

    assign err_id_o = r_err;

    resp_delay_line_l2 #(
        .N (MEM_LATENCY),
        .W ($bits(payload_t))
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_cap_valid),
        .in_data   (w_cap_payload),
        .out_valid (w_last_valid),
        .out_data  (w_last_payload)
    );

    // ------------------------------------------------------------------
    // Output steering. A non-responding write still rides the pipeline so
    // the outstanding count stays exact, but raises no r_valid.
    // ------------------------------------------------------------------
    assign w_resp       = w_last_valid & (w_last_payload.wen | c_resp_on_write);
    assign w_rvalid_nxt = w_resp ? w_last_payload.id : '0;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_occ;
            logic [ID_WIDTH-1:0]   r_rvalid;
            logic [DATA_WIDTH-1:0] r_rdata;
            logic [TAG_WIDTH-1:0]  r_rtag;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_occ    <= 1'b0;
                    r_rvalid <= '0;
                    r_rdata  <= '0;
                    r_rtag   <= '0;
                end else begin
                    r_occ    <= w_last_valid;
                    r_rvalid <= w_rvalid_nxt;
                    // Data only loads on a real response so it holds otherwise.
                    if (w_resp) begin
                        r_rdata <= data_r_rdata_i;
                        r_rtag  <= data_r_rtag_i;
                    end
                end
            end

            assign data_r_valid_o = r_rvalid;
            assign data_r_rdata_o = r_rdata;
            assign data_r_rtag_o  = r_rtag;
            // The entry retires when it leaves the output register.
            assign w_leave        = r_occ;
        end else begin : g_no_out_reg
            assign data_r_valid_o = w_rvalid_nxt;
            assign data_r_rdata_o = data_r_rdata_i;
            assign data_r_rtag_o  = data_r_rtag_i;
            assign w_leave        = w_last_valid;
        end
    endgenerate

    // ------------------------------------------------------------------
    // In-flight counter. At most one entry enters and one leaves per cycle,
    // and the pipeline depth bounds it, so it cannot wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else begin
            case ({w_cap_valid, w_leave})
                2'b10:   r_outstanding <= r_outstanding + c_cnt_one;
                2'b01:   r_outstanding <= r_outstanding - c_cnt_one;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign outstanding_o = r_outstanding;

endmodule : resp_demux_l2
`default_nettype wire

// File: tb/tb_resp_demux_l2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_resp_demux_l2
//  Description : Self-checking bench. Four demux configurations share one
//                request stream; each has its own bank driver and a reference
//                model that turns every observed handshake into an expected
//                response (due cycle, ID, data, tag) in a queue, which a
//                monitor compares against the outputs every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_resp_demux_l2;

    typedef struct {
        int          due;
        logic [15:0] id;
        logic [63:0] d;
        logic [7:0]  t;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic        wen;
    logic [15:0] id;
    int          cyc;
    int          n_checks;
    int          n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit is_onehot(input logic [15:0] v);
        return (v != 16'h0) && ($countones(v) == 1);
    endfunction

    // ------------------------------------------------------------------
    // Configurations: {MEM_LATENCY, OUT_REG, RESP_ON_WRITE}
    //   0: 1,0,1   1: 2,0,0   2: 1,1,1   3: 3,1,0
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 4; k++) begin : g_cfg
        localparam int ML  = (k == 1) ? 2 : (k == 3) ? 3 : 1;
        localparam int OR  = (k >= 2) ? 1 : 0;
        localparam int ROW = (k == 0 || k == 2) ? 1 : 0;
        localparam int OW  = $clog2(ML + OR + 1);

        logic [63:0]   bank_d;
        logic [7:0]    bank_t;
        logic [15:0]   rv;
        logic [63:0]   rd;
        logic [7:0]    rt;
        logic [OW-1:0] ost;
        logic          err;

        exp_t          rq[$];
        int            iss[$];
        bit            errx[int];
        logic [63:0]   sd[int];
        logic [7:0]    st[int];
        logic [63:0]   last_d;
        logic [7:0]    last_t;
        logic [15:0]   e_rv;
        logic [63:0]   e_d;
        logic [7:0]    e_t;
        logic [63:0]   nd;
        logic [7:0]    nt;

        resp_demux_l2 #(
            .ID_WIDTH      (16),
            .DATA_WIDTH    (64),
            .TAG_WIDTH     (8),
            .MEM_LATENCY   (ML),
            .OUT_REG       (OR),
            .RESP_ON_WRITE (ROW)
        ) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .data_req_i     (req),
            .data_gnt_i     (gnt),
            .data_wen_i     (wen),
            .data_ID_i      (id),
            .data_r_rdata_i (bank_d),
            .data_r_rtag_i  (bank_t),
            .data_r_valid_o (rv),
            .data_r_rdata_o (rd),
            .data_r_rtag_o  (rt),
            .outstanding_o  (ost),
            .err_id_o       (err)
        );

        initial begin
            bank_d = '0;
            bank_t = '0;
            last_d = '0;
            last_t = '0;
        end

        // Bank: returns the data chosen for a handshake exactly ML cycles
        // later, random filler otherwise.
        always @(posedge clk) begin
            #2;
            if (sd.exists(cyc)) begin
                bank_d = sd[cyc];
                bank_t = st[cyc];
                sd.delete(cyc);
                st.delete(cyc);
            end else begin
                bank_d = {$urandom(), $urandom()};
                bank_t = 8'($urandom());
            end
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                rq.delete();
                iss.delete();
                errx.delete();
                sd.delete();
                st.delete();
                last_d = '0;
                last_t = '0;
            end

            // Expected outputs for this cycle.
            e_rv = 16'h0;
            e_d  = (OR != 0) ? last_d : bank_d;
            e_t  = (OR != 0) ? last_t : bank_t;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e_rv   = rq[0].id;
                e_d    = rq[0].d;
                e_t    = rq[0].t;
                last_d = rq[0].d;
                last_t = rq[0].t;
                void'(rq.pop_front());
            end
            // An entry issued at t is in flight during cycles t+1..t+ML+OR.
            while (iss.size() > 0 && iss[0] + ML + OR < cyc) void'(iss.pop_front());

            chk($sformatf("cfg%0d r_valid", k), 64'(rv), 64'(e_rv));
            chk($sformatf("cfg%0d rdata", k), rd, e_d);
            chk($sformatf("cfg%0d rtag", k), 64'(rt), 64'(e_t));
            chk($sformatf("cfg%0d outstanding", k), 64'(ost), 64'(iss.size()));
            chk($sformatf("cfg%0d err_id", k), 64'(err), 64'(errx.exists(cyc)));
            if (errx.exists(cyc)) errx.delete(cyc);

            // Record this cycle's handshake, which completes at the next edge.
            if (rst_n && req && gnt) begin
                if (is_onehot(id)) begin
                    iss.push_back(cyc);
                    nd = {$urandom(), $urandom()};
                    nt = 8'($urandom());
                    sd[cyc + ML] = nd;
                    st[cyc + ML] = nt;
                    if (wen || ROW != 0) rq.push_back('{cyc + ML + OR, id, nd, nt});
                end else begin
                    errx[cyc + 1] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step(input logic r, input logic g, input logic w, input logic [15:0] i);
        @(posedge clk);
        #1;
        req = r;
        gnt = g;
        wen = w;
        id  = i;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b1, 16'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        req   = 1'b0;
        gnt   = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] one;
        logic [15:0] rid;
        int          sel;
        one      = 16'h0001;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        req      = 1'b0;
        gnt      = 1'b0;
        wen      = 1'b1;
        id       = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single read
        step(1'b1, 1'b1, 1'b1, 16'h0004);
        idle(5);
        // Back-to-back reads
        step(1'b1, 1'b1, 1'b1, 16'h0001);
        step(1'b1, 1'b1, 1'b1, 16'h0002);
        step(1'b1, 1'b1, 1'b1, 16'h8000);
        idle(6);
        // Write
        step(1'b1, 1'b1, 1'b0, 16'h0010);
        idle(6);
        // Bad IDs
        step(1'b1, 1'b1, 1'b1, 16'h0000);
        step(1'b1, 1'b1, 1'b1, 16'h0003);
        idle(6);
        // req without gnt, gnt without req
        step(1'b1, 1'b0, 1'b1, 16'h0020);
        step(1'b0, 1'b1, 1'b1, 16'h0040);
        idle(6);
        // Reset with three reads in flight, then a fresh read
        step(1'b1, 1'b1, 1'b1, 16'h0001);
        step(1'b1, 1'b1, 1'b1, 16'h0002);
        step(1'b1, 1'b1, 1'b1, 16'h0004);
        do_reset();
        idle(6);
        step(1'b1, 1'b1, 1'b1, 16'h0100);
        idle(6);

        // Randomised traffic with occasional mid-flight resets
        for (int i = 0; i < 2000; i++) begin
            sel = int'($urandom_range(7, 0));
            if (sel == 0)      rid = 16'h0;
            else if (sel == 1) rid = 16'($urandom());
            else               rid = one << $urandom_range(15, 0);
            step(($urandom() % 4) != 0, ($urandom() % 4) != 0, 1'($urandom()), rid);
            if (i % 500 == 499) do_reset();
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_resp_demux_l2
`default_nettype wire
